// File: rtl/gray_pattern_source.sv
// Gray-level test pattern source: frame/line timing plus ramp, checker and flat patterns.
// Optional PATTERN_MOTION_EN scrolls the ramp and checker patterns by frame_cnt.
module gray_pattern_source #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [10:0] H_BLANK   = 11'd160,
  parameter logic [10:0] V_PRE     = 11'd2,
  parameter logic [10:0] V_POST    = 11'd20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [7:0] level,
  output logic       per_frame_vsync,
  output logic       per_frame_href,
  output logic [7:0] per_img_Gray,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam logic [10:0] H_TOTAL = IMG_HDISP + H_BLANK;

  typedef enum logic [1:0] {
    IDLE,
    VPRE,
    ACTIVE,
    VPOST
  } state_t;

  state_t      r_state;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [1:0]  r_mode;
  logic [7:0]  r_level;
  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_gray;
  logic        r_done;
  logic [7:0]  r_cnt;

  state_t      w_state;
  state_t      w_first;
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic        w_line_end;
  logic        w_start;
  logic        w_end;
  logic        w_last_n;
  logic [7:0]  w_cnt_n;
  logic [1:0]  w_mode_n;
  logic [7:0]  w_level_n;
  logic        w_vsync_n;
  logic        w_href_n;
  logic [7:0]  w_xm;
  logic [7:0]  w_ym;
  logic [7:0]  w_gray_n;

  assign w_line_end = (r_x == H_TOTAL - 11'd1);
  assign w_first    = (V_PRE == 11'd0) ? ACTIVE : VPRE;

  // Next position and state; outputs are registered from these so they
  // line up with the state registers in the same cycle.
  always_comb begin
    w_state = r_state;
    w_x     = 11'd0;
    w_y     = r_y;
    w_start = 1'b0;
    w_end   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_y     = 11'd0;
        w_start = en;
      end
      VPRE: begin
        w_x = w_line_end ? 11'd0 : r_x + 11'd1;
        if (w_line_end) begin
          w_y = r_y + 11'd1;
          if (r_y == V_PRE - 11'd1) begin
            w_state = ACTIVE;
            w_y     = 11'd0;
          end
        end
      end
      ACTIVE: begin
        w_x = w_line_end ? 11'd0 : r_x + 11'd1;
        if (w_line_end) begin
          w_y = r_y + 11'd1;
          if (r_y == IMG_VDISP - 11'd1) begin
            if (V_POST == 11'd0) begin
              w_end = 1'b1;
            end else begin
              w_state = VPOST;
              w_y     = 11'd0;
            end
          end
        end
      end
      VPOST: begin
        w_x = w_line_end ? 11'd0 : r_x + 11'd1;
        if (w_line_end) begin
          w_y = r_y + 11'd1;
          if (r_y == V_POST - 11'd1)
            w_end = 1'b1;
        end
      end
    endcase
    if (w_end) begin
      w_start = en;
      w_state = IDLE;
      w_x     = 11'd0;
      w_y     = 11'd0;
    end
    if (w_start) begin
      w_state = w_first;
      w_x     = 11'd0;
      w_y     = 11'd0;
    end
  end

  assign w_last_n = (w_x == H_TOTAL - 11'd1) &&
                    (((w_state == VPOST) && (w_y == V_POST - 11'd1)) ||
                     ((w_state == ACTIVE) && (V_POST == 11'd0) &&
                      (w_y == IMG_VDISP - 11'd1)));

  assign w_cnt_n   = r_cnt + {7'd0, w_last_n};
  assign w_mode_n  = w_start ? mode : r_mode;
  assign w_level_n = w_start ? level : r_level;
  assign w_vsync_n = (w_state == VPRE) || (w_state == ACTIVE);
  assign w_href_n  = (w_state == ACTIVE) && (w_x < IMG_HDISP);

`ifdef PATTERN_MOTION_EN
  assign w_xm = w_x[7:0] + w_cnt_n;
  assign w_ym = w_y[7:0] + w_cnt_n;
`else
  assign w_xm = w_x[7:0];
  assign w_ym = w_y[7:0];
`endif

  always_comb begin
    w_gray_n = 8'h00;
    if (w_href_n) begin
      case (w_mode_n)
        2'd0:    w_gray_n = w_xm;
        2'd1:    w_gray_n = w_ym;
        2'd2:    w_gray_n = (w_xm[3] ^ w_y[3]) ? 8'hFF : 8'h00;
        default: w_gray_n = w_level_n;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= 11'd0;
      r_y     <= 11'd0;
      r_mode  <= 2'd0;
      r_level <= 8'd0;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_gray  <= 8'd0;
      r_done  <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_mode  <= w_mode_n;
      r_level <= w_level_n;
      r_vsync <= w_vsync_n;
      r_href  <= w_href_n;
      r_gray  <= w_gray_n;
      r_done  <= w_last_n;
      r_cnt   <= w_cnt_n;
    end
  end

  assign per_frame_vsync = r_vsync;
  assign per_frame_href  = r_href;
  assign per_img_Gray    = r_gray;
  assign frame_done      = r_done;
  assign frame_cnt       = r_cnt;

endmodule

// File: tb/tb_gray_pattern_source.sv
// Directed bench for gray_pattern_source: small-frame timing, mode capture,
// en/reset handling, and default-size checkerboard.
module tb_gray_pattern_source;

  logic       clk;
  logic       rst_n, en;
  logic [1:0] mode;
  logic [7:0] level;
  logic       vsync, href, done;
  logic [7:0] gray, cnt;

  logic       rst_b_n, en_b;
  logic [1:0] mode_b;
  logic [7:0] level_b;
  logic       vsync_b, href_b, done_b;
  logic [7:0] gray_b, cnt_b;

  int n_assert;
  int n_fail;

  gray_pattern_source #(
    .IMG_HDISP(11'd4),
    .IMG_VDISP(11'd3),
    .H_BLANK  (11'd2),
    .V_PRE    (11'd1),
    .V_POST   (11'd1)
  ) u_small (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .mode           (mode),
    .level          (level),
    .per_frame_vsync(vsync),
    .per_frame_href (href),
    .per_img_Gray   (gray),
    .frame_done     (done),
    .frame_cnt      (cnt)
  );

  gray_pattern_source u_dflt (
    .clk            (clk),
    .rst_n          (rst_b_n),
    .en             (en_b),
    .mode           (mode_b),
    .level          (level_b),
    .per_frame_vsync(vsync_b),
    .per_frame_href (href_b),
    .per_img_Gray   (gray_b),
    .frame_done     (done_b),
    .frame_cnt      (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input logic [1:0] m,
                                         input logic [7:0] lv,
                                         input int x, input int y,
                                         input int fc);
    logic [7:0] xm, ym, yr;
    xm = x[7:0];
    ym = y[7:0];
    yr = y[7:0];
`ifdef PATTERN_MOTION_EN
    xm = xm + fc[7:0];
    ym = ym + fc[7:0];
`endif
    case (m)
      2'd0:    return xm;
      2'd1:    return ym;
      2'd2:    return (xm[3] ^ yr[3]) ? 8'hFF : 8'h00;
      default: return lv;
    endcase
  endfunction

  logic [1:0] fm [4];
  logic [7:0] fl [4];

  initial begin
    int line, x, y;
    logic act;
    n_assert = 0;
    n_fail   = 0;
    fm[0] = 2'd0; fm[1] = 2'd0; fm[2] = 2'd3; fm[3] = 2'd1;
    fl[0] = 8'h00; fl[1] = 8'h00; fl[2] = 8'h5A; fl[3] = 8'h33;

    rst_n = 1'b1; en = 1'b0; mode = 2'd0; level = 8'd0;
    rst_b_n = 1'b1; en_b = 1'b0; mode_b = 2'd2; level_b = 8'd0;
    #2;
    rst_n = 1'b0;
    rst_b_n = 1'b0;
    #1;
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_gray", gray, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt, 0);

    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_vsync", vsync, 0);
    end

    en = 1'b1;
    tick();
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 30; c++) begin
        line = c / 6;
        x    = c % 6;
        y    = line - 1;
        act  = (line >= 1) && (line <= 3) && (x < 4);
        chk($sformatf("vsync f%0d c%0d", f, c), vsync, line < 4);
        chk($sformatf("href f%0d c%0d", f, c), href, act);
        chk($sformatf("gray f%0d c%0d", f, c), gray,
            act ? exp_pix(fm[f], fl[f], x, y, f) : 8'h00);
        chk($sformatf("done f%0d c%0d", f, c), done, c == 29);
        chk($sformatf("cnt f%0d c%0d", f, c), cnt,
            (c == 29) ? f + 1 : f);
        if (f == 1 && c == 10) begin
          mode = 2'd3; level = 8'h5A;
        end
        if (f == 2 && c == 8) begin
          mode = 2'd1; level = 8'h33;
        end
        if (f == 3 && c == 10)
          en = 1'b0;
        tick();
      end
    end

    for (int i = 0; i < 3; i++) begin
      chk("post_vsync", vsync, 0);
      chk("post_href", href, 0);
      chk("post_gray", gray, 0);
      chk("post_done", done, 0);
      chk("post_cnt", cnt, 4);
      tick();
    end

    mode = 2'd0;
    en   = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) tick();
    chk("mid_vsync", vsync, 1);
    chk("mid_gray", gray, exp_pix(2'd0, 8'd0, 3, 0, 4));
    rst_n = 1'b0;
    #1;
    chk("arst_vsync", vsync, 0);
    chk("arst_href", href, 0);
    chk("arst_gray", gray, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", cnt, 0);
    #1;
    rst_n = 1'b1;
    en    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rel_vsync", vsync, 0);
      chk("rel_cnt", cnt, 0);
    end

    rst_b_n = 1'b1;
    en_b    = 1'b1;
    tick();
    chk("dflt_vsync", vsync_b, 1);
    for (int c = 0; c < 8016; c++) begin
      line = c / 800;
      x    = c % 800;
      if ((line == 2 || line == 10) && x < 16) begin
        chk($sformatf("chk_href l%0d x%0d", line, x), href_b, 1);
        chk($sformatf("chk_gray l%0d x%0d", line, x), gray_b,
            ((x >= 8) ^ (line == 10)) ? 8'hFF : 8'h00);
      end
      if (c < 8015) tick();
    end
    chk("dflt_done", done_b, 0);
    chk("dflt_cnt", cnt_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
